tv80_bus_responder: RTL and testbench



---
 rtl/tv80_bus_responder.sv | 201 ++++++++++++++++++++
 tb/tb_tv80_bus_responder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tv80_bus_responder.sv
// Posedge-only memory/IO target for the tv80s bus: byte RAM, IO page, interrupt vector,
// programmable wait states, per-class cycle counters and last memory-write capture.
module tv80_bus_responder #(
  parameter int unsigned MEM_AW   = 16,
  parameter logic [7:0]  IO_PAGE  = 8'h10,
  parameter int unsigned M1_WAIT  = 0,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1,
  parameter logic [7:0]  INTA_VEC = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_do,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  di,
  output logic        wait_n,
  output logic [15:0] fetch_cnt,
  output logic [15:0] mem_rd_cnt,
  output logic [15:0] mem_wr_cnt,
  output logic [15:0] io_rd_cnt,
  output logic [15:0] io_wr_cnt,
  output logic [15:0] last_wr_addr,
  output logic [7:0]  last_wr_data
);

  typedef enum logic [2:0] {
    ClsNone, ClsRefresh, ClsInta, ClsFetch, ClsMemRd, ClsMemWr, ClsIoRd, ClsIoWr
  } cls_e;

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  logic [7:0] mem [2**MEM_AW];

  cls_e        cls, cls_q;
  logic        cur_idle, prev_idle, start;
  logic [15:0] acc_addr;
  logic [MEM_AW-1:0] ram_idx;
  logic        ram_we;
  logic [7:0]  di_q;
  logic [7:0]  cls_wait;

  logic [15:0] fetch_cnt_q, fetch_cnt_d, mem_rd_cnt_q, mem_rd_cnt_d, mem_wr_cnt_q, mem_wr_cnt_d;
  logic [15:0] io_rd_cnt_q, io_rd_cnt_d, io_wr_cnt_q, io_wr_cnt_d;
  logic [15:0] last_wr_addr_q, last_wr_addr_d;
  logic [7:0]  last_wr_data_q, last_wr_data_d;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wait_n_q, wait_n_d;

  // Priority order matters: INTA also has m1_n low, refresh also has mreq_n low.
  always_comb begin
    cls = ClsNone;
    if (!iorq_n && !m1_n)                cls = ClsInta;
    else if (!mreq_n && !rfsh_n)         cls = ClsRefresh;
    else if (!mreq_n && !m1_n && !rd_n)  cls = ClsFetch;
    else if (!mreq_n && !rd_n)           cls = ClsMemRd;
    else if (!mreq_n && !wr_n)           cls = ClsMemWr;
    else if (!iorq_n && !rd_n)           cls = ClsIoRd;
    else if (!iorq_n && !wr_n)           cls = ClsIoWr;
  end

  assign cur_idle  = (cls == ClsNone) || (cls == ClsRefresh);
  assign prev_idle = (cls_q == ClsNone) || (cls_q == ClsRefresh);
  assign start     = prev_idle && !cur_idle;

  assign acc_addr = iorq_n ? A : {IO_PAGE, A[7:0]};
  assign ram_idx  = acc_addr[MEM_AW-1:0];
  assign ram_we   = !reset && ((cls == ClsMemWr) || (cls == ClsIoWr));

  // RAM itself is never reset; the bench preloads it directly.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_idx] <= cpu_do;
  end

  always_ff @(posedge clk) begin
    if (reset)                   di_q <= 8'h00;
    else if (cls == ClsInta)     di_q <= INTA_VEC;
    else if (cls != ClsRefresh)  di_q <= mem[ram_idx];
  end

  always_comb begin
    fetch_cnt_d    = fetch_cnt_q;
    mem_rd_cnt_d   = mem_rd_cnt_q;
    mem_wr_cnt_d   = mem_wr_cnt_q;
    io_rd_cnt_d    = io_rd_cnt_q;
    io_wr_cnt_d    = io_wr_cnt_q;
    last_wr_addr_d = last_wr_addr_q;
    last_wr_data_d = last_wr_data_q;
    if (start) begin
      case (cls)
        ClsFetch: fetch_cnt_d  = fetch_cnt_q + 16'd1;
        ClsMemRd: mem_rd_cnt_d = mem_rd_cnt_q + 16'd1;
        ClsMemWr: mem_wr_cnt_d = mem_wr_cnt_q + 16'd1;
        ClsIoRd:  io_rd_cnt_d  = io_rd_cnt_q + 16'd1;
        ClsIoWr:  io_wr_cnt_d  = io_wr_cnt_q + 16'd1;
        default: ;
      endcase
    end
    // Reloaded every cycle of the write so the final data on the bus is kept.
    if (cls == ClsMemWr) begin
      last_wr_addr_d = A;
      last_wr_data_d = cpu_do;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q          <= ClsNone;
      fetch_cnt_q    <= 16'h0000;
      mem_rd_cnt_q   <= 16'h0000;
      mem_wr_cnt_q   <= 16'h0000;
      io_rd_cnt_q    <= 16'h0000;
      io_wr_cnt_q    <= 16'h0000;
      last_wr_addr_q <= 16'h0000;
      last_wr_data_q <= 8'h00;
    end else begin
      cls_q          <= cls;
      fetch_cnt_q    <= fetch_cnt_d;
      mem_rd_cnt_q   <= mem_rd_cnt_d;
      mem_wr_cnt_q   <= mem_wr_cnt_d;
      io_rd_cnt_q    <= io_rd_cnt_d;
      io_wr_cnt_q    <= io_wr_cnt_d;
      last_wr_addr_q <= last_wr_addr_d;
      last_wr_data_q <= last_wr_data_d;
    end
  end

  always_comb begin
    case (cls)
      ClsFetch:          cls_wait = 8'(M1_WAIT);
      ClsMemRd, ClsMemWr: cls_wait = 8'(MEM_WAIT);
      ClsIoRd, ClsIoWr:  cls_wait = 8'(IO_WAIT);
      default:           cls_wait = 8'd0;
    endcase
  end

  // Wait FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      wait_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
    end
  end

  // Wait FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cls_wait == 8'd0) begin
            state_d = StHold;
          end else begin
            state_d = StWait;
            cnt_d   = cls_wait - 8'd1;
          end
        end
      end
      StWait: begin
        if (cur_idle)            state_d = StIdle;
        else if (cnt_q == 8'd0)  state_d = StHold;
        else                     cnt_d   = cnt_q - 8'd1;
      end
      StHold: begin
        if (cur_idle) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Wait FSM: registered wait_n level for the next clock.
  always_comb begin
    wait_n_d = 1'b1;
    if (state_q == StIdle && start && cls_wait != 8'd0)        wait_n_d = 1'b0;
    if (state_q == StWait && !cur_idle && cnt_q != 8'd0)       wait_n_d = 1'b0;
  end

  assign di           = di_q;
  assign wait_n       = wait_n_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign mem_rd_cnt   = mem_rd_cnt_q;
  assign mem_wr_cnt   = mem_wr_cnt_q;
  assign io_rd_cnt    = io_rd_cnt_q;
  assign io_wr_cnt    = io_wr_cnt_q;
  assign last_wr_addr = last_wr_addr_q;
  assign last_wr_data = last_wr_data_q;

endmodule

// File: tb/tb_tv80_bus_responder.sv
// Directed bench for tv80_bus_responder: bench-driven bus cycles, read-data scoreboard,
// wait-state counting, counter/last-write model.
module tb_tv80_bus_responder;

  localparam int KFetch   = 0;
  localparam int KMemRd   = 1;
  localparam int KMemWr   = 2;
  localparam int KIoRd    = 3;
  localparam int KIoWr    = 4;
  localparam int KInta    = 5;
  localparam int KRefresh = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1;
  logic        rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic [7:0]  di;
  logic        wait_n;
  logic [15:0] fetch_cnt, mem_rd_cnt, mem_wr_cnt, io_rd_cnt, io_wr_cnt, last_wr_addr;
  logic [7:0]  last_wr_data;

  tv80_bus_responder #(
    .MEM_AW  (16),
    .IO_PAGE (8'h10),
    .M1_WAIT (0),
    .MEM_WAIT(2),
    .IO_WAIT (1),
    .INTA_VEC(8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .A           (A),
    .cpu_do      (cpu_do),
    .m1_n        (m1_n),
    .mreq_n      (mreq_n),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .rfsh_n      (rfsh_n),
    .di          (di),
    .wait_n      (wait_n),
    .fetch_cnt   (fetch_cnt),
    .mem_rd_cnt  (mem_rd_cnt),
    .mem_wr_cnt  (mem_wr_cnt),
    .io_rd_cnt   (io_rd_cnt),
    .io_wr_cnt   (io_wr_cnt),
    .last_wr_addr(last_wr_addr),
    .last_wr_data(last_wr_data)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  sb [$];
  logic [7:0]  model [logic [15:0]];
  logic [15:0] e_fetch = 0, e_mem_rd = 0, e_mem_wr = 0, e_io_rd = 0, e_io_wr = 0;
  logic [15:0] e_wr_addr = 0;
  logic [7:0]  e_wr_data = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_fetch_cnt"}, fetch_cnt, e_fetch);
    chk({tag, "_mem_rd_cnt"}, mem_rd_cnt, e_mem_rd);
    chk({tag, "_mem_wr_cnt"}, mem_wr_cnt, e_mem_wr);
    chk({tag, "_io_rd_cnt"}, io_rd_cnt, e_io_rd);
    chk({tag, "_io_wr_cnt"}, io_wr_cnt, e_io_wr);
    chk({tag, "_last_wr_addr"}, last_wr_addr, e_wr_addr);
    chk({tag, "_last_wr_data"}, last_wr_data, e_wr_data);
  endtask

  task automatic idle_strobes();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  // One bus cycle: drive at negedge, count wait_n low samples, compare read data.
  task automatic bus_cycle(input int kind, input logic [15:0] addr, input logic [7:0] data,
                           input int exp_lows, input string tag);
    logic [15:0] ra;
    logic [7:0]  exp;
    int          lows;
    bit          is_rd;
    ra    = (kind == KIoRd || kind == KIoWr) ? {8'h10, addr[7:0]} : addr;
    is_rd = 1'b1;
    @(negedge clk);
    case (kind)
      KFetch:   begin mreq_n = 0; m1_n = 0; rd_n = 0; sb.push_back(model[ra]); e_fetch++; end
      KMemRd:   begin mreq_n = 0; rd_n = 0; sb.push_back(model[ra]); e_mem_rd++; end
      KMemWr:   begin
        mreq_n = 0; wr_n = 0; model[ra] = data; e_mem_wr++;
        e_wr_addr = addr; e_wr_data = data; is_rd = 1'b0;
      end
      KIoRd:    begin iorq_n = 0; rd_n = 0; sb.push_back(model[ra]); e_io_rd++; end
      KIoWr:    begin iorq_n = 0; wr_n = 0; model[ra] = data; e_io_wr++; is_rd = 1'b0; end
      KInta:    begin iorq_n = 0; m1_n = 0; sb.push_back(8'hFF); end
      KRefresh: begin mreq_n = 0; rfsh_n = 0; sb.push_back(model[A]); end
      default:  is_rd = 1'b0;
    endcase
    A = addr;
    cpu_do = data;
    lows = 0;
    @(negedge clk);
    while (wait_n !== 1'b1 && lows < 16) begin
      lows++;
      @(negedge clk);
    end
    chk({tag, "_waits"}, lows, exp_lows);
    if (is_rd) begin
      exp = sb.pop_front();
      chk({tag, "_di"}, di, exp);
    end
    idle_strobes();
  endtask

  initial begin
    dut.mem[16'h0000] = 8'hFD; model[16'h0000] = 8'hFD;
    dut.mem[16'h0001] = 8'hCB; model[16'h0001] = 8'hCB;
    dut.mem[16'h0002] = 8'h23; model[16'h0002] = 8'h23;
    dut.mem[16'h0003] = 8'h16; model[16'h0003] = 8'h16;
    dut.mem[16'hF0D7] = 8'h89; model[16'hF0D7] = 8'h89;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_di", di, 8'h00);
    chk("rst_wait_n", wait_n, 1'b1);
    chk_counters("rst");
    reset = 1'b0;

    // FD CB 23 16 bus trace: two fetches, d and op reads, read-modify-write at IY+d.
    bus_cycle(KFetch, 16'h0000, 8'h00, 0, "fetch0");
    bus_cycle(KFetch, 16'h0001, 8'h00, 0, "fetch1");
    bus_cycle(KMemRd, 16'h0002, 8'h00, 2, "rd_disp");
    bus_cycle(KMemRd, 16'h0003, 8'h00, 2, "rd_op");
    bus_cycle(KMemRd, 16'hF0D7, 8'h00, 2, "rd_iyd");
    bus_cycle(KMemWr, 16'hF0D7, 8'h12, 2, "wr_iyd");
    chk("ram_f0d7", dut.mem[16'hF0D7], 8'h12);
    chk_counters("prog");

    bus_cycle(KIoWr, 16'h0042, 8'h5A, 1, "iowr42");
    bus_cycle(KIoRd, 16'h0042, 8'h00, 1, "iord42");
    chk("ram_1042", dut.mem[16'h1042], 8'h5A);
    chk_counters("io");

    bus_cycle(KMemRd, 16'h0002, 8'h00, 2, "rd_pre_rfsh");
    bus_cycle(KRefresh, 16'hF0D7, 8'h00, 0, "refresh");
    chk("rfsh_ram_f0d7", dut.mem[16'hF0D7], 8'h12);
    bus_cycle(KInta, 16'h0000, 8'h00, 0, "inta");
    chk_counters("rfsh_inta");

    bus_cycle(KMemRd, 16'hF0D7, 8'h00, 2, "rd_after_wr");

    // Preset mem_rd_cnt just below wrap.
    @(negedge clk);
    force dut.mem_rd_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.mem_rd_cnt_q;
    @(negedge clk);
    e_mem_rd = 16'hFFFF;
    chk("preset_mem_rd_cnt", mem_rd_cnt, e_mem_rd);
    bus_cycle(KMemRd, 16'h0000, 8'h00, 2, "rd_wrap");
    chk("wrap_mem_rd_cnt", mem_rd_cnt, 16'h0000);

    // Abort a read with one wait still pending.
    @(negedge clk);
    A = 16'h0001; mreq_n = 1'b0; rd_n = 1'b0; e_mem_rd++;
    @(negedge clk);
    chk("abort_wait_low", wait_n, 1'b0);
    idle_strobes();
    @(negedge clk);
    chk("abort_wait_release", wait_n, 1'b1);
    bus_cycle(KMemRd, 16'h0002, 8'h00, 2, "rd_post_abort");
    chk_counters("abort");

    // Reset in the middle of a wait sequence.
    @(negedge clk);
    A = 16'h0003; mreq_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    chk("rstwait_low", wait_n, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    idle_strobes();
    e_fetch = 0; e_mem_rd = 0; e_mem_wr = 0; e_io_rd = 0; e_io_wr = 0;
    e_wr_addr = 16'h0000; e_wr_data = 8'h00;
    chk("rstwait_wait_n", wait_n, 1'b1);
    chk("rstwait_di", di, 8'h00);
    chk_counters("rstwait");
    reset = 1'b0;
    bus_cycle(KFetch, 16'h0000, 8'h00, 0, "fetch_post_rst");
    chk("post_rst_fetch_cnt", fetch_cnt, e_fetch);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
